// File: rtl/mult_pkg.sv
// Shared definitions for the arbitrated 32x32 multiplier: widths, multiplier
// timing and the arbiter FSM state encoding.
package mult_pkg;

    localparam int OP_W     = 32;
    localparam int PROD_W   = 64;

    // mult32x32_fast walks the B operand one slice per busy cycle
    localparam int MULT_LAT = 4;
    localparam int SLICE_W  = OP_W / MULT_LAT;
    localparam int SLICE_LG = $clog2(SLICE_W);
    localparam int STEP_W   = $clog2(MULT_LAT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_t;

    function automatic logic [1:0] id_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mult32x32_fast.sv
// Sequential 32x32 unsigned multiplier: one start pulse, busy rises the next
// cycle and stays high for MULT_LAT cycles while byte slices are accumulated.
module mult32x32_fast
    import mult_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [OP_W-1:0]   a_i,
    input  logic [OP_W-1:0]   b_i,
    output logic              busy_o,
    output logic [PROD_W-1:0] product_o
);

    logic [OP_W-1:0]           a_q;
    logic [OP_W-1:0]           b_q;
    logic [PROD_W-1:0]         acc_q;
    logic [STEP_W-1:0]         step_q;
    logic                      busy_q;

    logic [STEP_W+SLICE_LG-1:0] bit_off;
    logic [SLICE_W-1:0]         b_slice;
    logic [PROD_W-1:0]          partial;

    always_comb begin
        bit_off = {step_q, SLICE_LG'(0)};
        b_slice = SLICE_W'(b_q >> bit_off);
        partial = (PROD_W'(a_q) * PROD_W'(b_slice)) << bit_off;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            acc_q  <= '0;
            step_q <= '0;
            busy_q <= 1'b0;
        end else if (start_i) begin
            a_q    <= a_i;
            b_q    <= b_i;
            acc_q  <= '0;
            step_q <= '0;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            acc_q  <= acc_q + partial;
            step_q <= step_q + 1'b1;
            if (step_q == STEP_W'(MULT_LAT - 1)) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign busy_o    = busy_q;
    assign product_o = acc_q;

endmodule

// File: rtl/mult32x32_arb.sv
// Two-requester round-robin front end sharing one mult32x32_fast.
// Define MULT32X32_ARB_STATS_EN to add saturating per-requester op counters.
module mult32x32_arb
    import mult_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [OP_W-1:0]   a0,
    input  logic [OP_W-1:0]   b0,
    input  logic [OP_W-1:0]   a1,
    input  logic [OP_W-1:0]   b1,
    output logic [1:0]        gnt,
    output logic [1:0]        done,
    output logic [PROD_W-1:0] product,
    output logic              arb_busy
`ifdef MULT32X32_ARB_STATS_EN
    ,
    output logic [15:0]       ops0,
    output logic [15:0]       ops1
`endif
);

    arb_state_t        state_q, state_d;
    logic [OP_W-1:0]   a_q, a_d;
    logic [OP_W-1:0]   b_q, b_d;
    logic              id_q, id_d;
    logic              last_q, last_d;
    logic              first_wait_q, first_wait_d;
    logic [PROD_W-1:0] product_q, product_d;

    logic              winner;
    logic              mult_rst;
    logic              mult_start;
    logic              mult_busy;
    logic [PROD_W-1:0] mult_product;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        id_d         = id_q;
        last_d       = last_q;
        first_wait_d = first_wait_q;
        product_d    = product_q;
        winner       = 1'b0;
        mult_start   = 1'b0;
        gnt          = 2'b00;
        done         = 2'b00;

        case (state_q)
            ST_IDLE: begin
                if (req != 2'b00) begin
                    // Contention goes to whoever was not served last
                    winner  = (req == 2'b11) ? ~last_q : req[1];
                    id_d    = winner;
                    a_d     = winner ? a1 : a0;
                    b_d     = winner ? b1 : b0;
                    gnt     = id_onehot(winner);
                    state_d = ST_START;
                end
            end
            ST_START: begin
                mult_start   = 1'b1;
                first_wait_d = 1'b1;
                state_d      = ST_WAIT;
            end
            ST_WAIT: begin
                // Busy is not yet valid in the first WAIT cycle
                first_wait_d = 1'b0;
                if (!first_wait_q && !mult_busy) begin
                    product_d = mult_product;
                    state_d   = ST_DONE;
                end
            end
            ST_DONE: begin
                done    = id_onehot(id_q);
                last_d  = id_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            a_q          <= '0;
            b_q          <= '0;
            id_q         <= 1'b0;
            last_q       <= 1'b1;
            first_wait_q <= 1'b0;
            product_q    <= '0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            id_q         <= id_d;
            last_q       <= last_d;
            first_wait_q <= first_wait_d;
            product_q    <= product_d;
        end
    end

    assign product  = product_q;
    assign arb_busy = (state_q != ST_IDLE);
    assign mult_rst = ~reset;

    mult32x32_fast u_mult (
        .clk       (clk),
        .rst       (mult_rst),
        .start_i   (mult_start),
        .a_i       (a_q),
        .b_i       (b_q),
        .busy_o    (mult_busy),
        .product_o (mult_product)
    );

`ifdef MULT32X32_ARB_STATS_EN
    logic [15:0] ops0_q;
    logic [15:0] ops1_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ops0_q <= '0;
            ops1_q <= '0;
        end else begin
            if (done[0] && (ops0_q != 16'hFFFF)) ops0_q <= ops0_q + 1'b1;
            if (done[1] && (ops1_q != 16'hFFFF)) ops1_q <= ops1_q + 1'b1;
        end
    end

    assign ops0 = ops0_q;
    assign ops1 = ops1_q;
`endif

endmodule

// File: tb/tb_mult32x32_arb.sv
// Directed scoreboard bench for mult32x32_arb: expected results are queued on
// issue and matched against done/product events logged by a negedge monitor.
module tb_mult32x32_arb;
    import mult_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [1:0]        req = 2'b00;
    logic [OP_W-1:0]   a0 = '0;
    logic [OP_W-1:0]   b0 = '0;
    logic [OP_W-1:0]   a1 = '0;
    logic [OP_W-1:0]   b1 = '0;
    logic [1:0]        gnt;
    logic [1:0]        done;
    logic [PROD_W-1:0] product;
    logic              arb_busy;
`ifdef MULT32X32_ARB_STATS_EN
    logic [15:0]       ops0;
    logic [15:0]       ops1;
`endif

    mult32x32_arb dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .a0       (a0),
        .b0       (b0),
        .a1       (a1),
        .b1       (b1),
        .gnt      (gnt),
        .done     (done),
        .product  (product),
        .arb_busy (arb_busy)
`ifdef MULT32X32_ARB_STATS_EN
        ,
        .ops0     (ops0),
        .ops1     (ops1)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  id;
        logic [63:0] prod;
    } exp_t;

    int          checks = 0;
    int          failures = 0;
    exp_t        sb_q[$];
    logic [1:0]  gnt_log[$];
    int          gnt_cyc[$];
    logic [1:0]  done_log[$];
    logic [63:0] prod_log[$];
    int          done_cyc[$];
    int          cyc = 0;
    int          bad = 0;
    int          gnt_rd = 0;
    int          done_rd = 0;

    // Protocol monitor: logs events and counts overlap/one-hot violations
    always @(negedge clk) begin
        cyc++;
        if (gnt != 2'b00) begin
            gnt_log.push_back(gnt);
            gnt_cyc.push_back(cyc);
            if (arb_busy) bad++;
        end
        if (done != 2'b00) begin
            done_log.push_back(done);
            prod_log.push_back(product);
            done_cyc.push_back(cyc);
        end
        if ((gnt != 2'b00) && (done != 2'b00)) bad++;
        if ((gnt == 2'b11) || (done == 2'b11)) bad++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic r, input logic [31:0] a, input logic [31:0] b);
        exp_t e;
        if (r) begin a1 = a; b1 = b; end
        else   begin a0 = a; b0 = b; end
        req[r] = 1'b1;
        e.id   = r ? 2'b10 : 2'b01;
        e.prod = 64'(a) * 64'(b);
        sb_q.push_back(e);
    endtask

    task automatic wait_gnt(input string tag, input logic [1:0] exp);
        int k = 0;
        while ((gnt_log.size() <= gnt_rd) && (k < 64)) begin
            @(negedge clk); #1;
            k++;
        end
        if (gnt_log.size() > gnt_rd) begin
            check(tag, 64'(gnt_log[gnt_rd]), 64'(exp));
            gnt_rd++;
        end else begin
            checks++;
            failures++;
            $error("FAIL %s observed=no_gnt expected=0x%0h", tag, exp);
        end
    endtask

    task automatic wait_done(input string tag);
        exp_t e;
        int   k = 0;
        while ((done_log.size() <= done_rd) && (k < 64)) begin
            @(negedge clk); #1;
            k++;
        end
        if (done_log.size() <= done_rd) begin
            checks++;
            failures++;
            $error("FAIL %s observed=no_done expected=done_pulse", tag);
        end else if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=done_0x%0h expected=no_done", tag, done_log[done_rd]);
            done_rd++;
        end else begin
            e = sb_q.pop_front();
            check({tag, "_done"}, 64'(done_log[done_rd]), 64'(e.id));
            check({tag, "_prod"}, prod_log[done_rd], e.prod);
            done_rd++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
    endtask

    task automatic single_op(input string tag, input logic r, input logic [31:0] a,
                             input logic [31:0] b);
        issue(r, a, b);
        wait_gnt({tag, "_gnt"}, r ? 2'b10 : 2'b01);
        @(posedge clk); #1;
        req[r] = 1'b0;
        wait_done(tag);
    endtask

    initial begin
        int base;
        int n;

        // Reset state
        tick(3);
        check("rst_gnt", 64'(gnt), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_product", product, 64'(0));
        check("rst_busy", 64'(arb_busy), 64'(0));
        reset = 1'b1;
        tick(2);

        // Basic op; operands changed after gnt must be ignored
        issue(1'b0, 32'd3, 32'd5);
        wait_gnt("t1_gnt", 2'b01);
        @(posedge clk); #1;
        req = 2'b00;
        a0  = 32'hDEAD_BEEF;
        b0  = 32'h0000_0000;
        check("t1_busy", 64'(arb_busy), 64'(1));
        wait_done("t1");
        check("t1_latency", 64'(done_cyc[done_rd-1] - gnt_cyc[gnt_rd-1]), 64'(MULT_LAT + 3));

        // Simultaneous requests right after reset: requester 0 first
        do_reset();
        a0 = 32'd205961014; b0 = 32'd318947199;
        a1 = 32'd46902;     b1 = 32'd49023;
        sb_q.push_back('{id: 2'b01, prod: 64'd65690688518499786});
        sb_q.push_back('{id: 2'b10, prod: 64'd2299276746});
        req = 2'b11;
        wait_gnt("t2_gnt0", 2'b01);
        @(posedge clk); #1;
        req = 2'b10;
        wait_gnt("t2_gnt1", 2'b10);
        @(posedge clk); #1;
        req = 2'b00;
        wait_done("t2a");
        wait_done("t2b");

        // Full-width product
        single_op("t4", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("t4_literal", product, 64'hFFFF_FFFE_0000_0001);

        // Both held for four ops: alternating grants at minimum spacing
        base = gnt_rd;
        a0 = 32'd7;  b0 = 32'd9;
        a1 = 32'd11; b1 = 32'd13;
        for (int k = 0; k < 4; k++) begin
            sb_q.push_back('{id: (k % 2) ? 2'b10 : 2'b01,
                             prod: (k % 2) ? 64'd143 : 64'd63});
        end
        req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_gnt($sformatf("t3_gnt%0d", k), (k % 2) ? 2'b10 : 2'b01);
        end
        @(posedge clk); #1;
        req = 2'b00;
        for (int k = 1; k < 4; k++) begin
            check($sformatf("t3_spacing%0d", k), 64'(gnt_cyc[base+k] - gnt_cyc[base+k-1]),
                  64'(MULT_LAT + 4));
        end
        for (int k = 0; k < 4; k++) begin
            wait_done($sformatf("t3_op%0d", k));
        end

        // Reset during WAIT aborts silently
        a0 = 32'd100; b0 = 32'd200;
        req = 2'b01;
        wait_gnt("t5_gnt", 2'b01);
        @(posedge clk); #1;
        req = 2'b00;
        tick(2);
        check("t5_busy_pre", 64'(arb_busy), 64'(1));
        #2 reset = 1'b0;
        #1;
        check("t5_gnt", 64'(gnt), 64'(0));
        check("t5_done", 64'(done), 64'(0));
        check("t5_product", product, 64'(0));
        check("t5_busy", 64'(arb_busy), 64'(0));
        tick(2);
        reset = 1'b1;
        n = done_log.size();
        tick(15);
        check("t5_no_done", 64'(done_log.size()), 64'(n));

        // Recovery op; requester 1 raises and withdraws req while busy
        issue(1'b0, 32'd6, 32'd7);
        wait_gnt("t6_gnt", 2'b01);
        @(posedge clk); #1;
        req = 2'b10;
        tick(2);
        req = 2'b00;
        wait_done("t6");
        tick(12);
        check("t6_withdrawn", 64'(gnt_log.size()), 64'(gnt_rd));

`ifdef MULT32X32_ARB_STATS_EN
        single_op("t7a", 1'b0, 32'd2, 32'd3);
        single_op("t7b", 1'b1, 32'd4, 32'd5);
        single_op("t7c", 1'b0, 32'd8, 32'd9);
        check("t7_ops0", 64'(ops0), 64'(3));
        check("t7_ops1", 64'(ops1), 64'(1));
`endif

        tick(2);
        check("protocol_violations", 64'(bad), 64'(0));
        check("sb_empty", 64'(sb_q.size()), 64'(0));
        check("no_extra_done", 64'(done_log.size()), 64'(done_rd));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult32x32_arb.md
MULT32X32_ARB -- requirements
Module: mult32x32_arb

Interface
REQ-001 Parameters: none; requester count fixed at 2.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req  input  2  per-requester operation request; bit i = requester i.
REQ-005 a0, b0  input  32 each  requester 0 operands.
REQ-006 a1, b1  input  32 each  requester 1 operands.
REQ-007 gnt  output  2  one-hot, one-cycle pulse: operands of that requester captured this cycle.
REQ-008 done  output  2  one-hot, one-cycle pulse: product valid for that requester.
REQ-009 product  output  64  result of the last completed operation; held until next completion.
REQ-010 arb_busy  output  1  high in any state other than IDLE.

Function
REQ-011 FSM states IDLE, START, WAIT, DONE; one state per cycle except WAIT.
REQ-012 IDLE: no req bit set -> stay; else select winner, latch its a/b and id, pulse gnt[winner], go START.
REQ-013 Arbitration round-robin: both requesting -> the one not served last wins; after reset, requester 0 has priority.
REQ-014 START: drive multiplier start=1 with latched operands for exactly one cycle, go WAIT.
REQ-015 WAIT: first WAIT cycle ignores multiplier busy (busy rises one cycle after start); thereafter busy=0 -> go DONE.
REQ-016 DONE: register multiplier product into product, pulse done[id], update last-served pointer, go IDLE.
REQ-017 Minimum gnt-to-gnt spacing for back-to-back requests = multiplier latency + 4 cycles; no overlap of operations.
REQ-018 Operands sampled only in the gnt cycle; later changes to a/b ignored for that operation.
REQ-019 Requester holds req until it sees gnt; req dropped before gnt = request withdrawn, no gnt, no done.
REQ-020 req held after gnt = new request, arbitrated normally in the next IDLE.
REQ-021 product unsigned 64-bit, full width, no truncation; 0xFFFFFFFF*0xFFFFFFFF supported.
REQ-022 gnt and done never asserted in the same cycle; each at most one bit high.

Reset
REQ-023 reset=0 asynchronously forces IDLE; gnt=0, done=0, product=0, arb_busy=0, last-served pointer = requester 1 (so requester 0 wins first).
REQ-024 reset mid-operation aborts it silently: no done pulse for the in-flight id after reset release.
REQ-025 Internal multiplier reset driven as ~reset (multiplier reset is active-high).

Configuration
REQ-026 Macro MULT32X32_ARB_STATS_EN defined: adds outputs ops0, ops1 (16-bit each), incremented on done[0]/done[1], saturating at 0xFFFF, cleared by reset.
REQ-027 Macro undefined: ports ops0/ops1 and counters absent; all other behaviour identical.

Structure
REQ-028 Shared package mult_pkg holds the FSM state enum (arb_state_t) and the width constants OP_W=32, PROD_W=64.
REQ-029 One sub-module: mult32x32_fast, instantiated once, driven only by this block.
REQ-030 Operand/id latches, round-robin pointer, FSM and product register reside in mult32x32_arb.

Verification
REQ-031 Reset release, req=01, a0=3, b0=5 -> gnt=01 next edge, done=01 later, product=15.
REQ-032 req=11 in one cycle, a0=205961014, b0=318947199, a1=46902, b1=49023 -> requester 0 served first (product 65690688518499786), then requester 1 (product 2299276746); done order 01 then 10.
REQ-033 Both requesters held high for 4 operations -> grants alternate 01,10,01,10; no gnt during arb_busy.
REQ-034 a1=b1=0xFFFFFFFF, req=10 -> product 0xFFFFFFFE00000001, done=10.
REQ-035 reset asserted in WAIT -> outputs zero immediately; after release no done; next req=01 completes normally.
REQ-036 With MULT32X32_ARB_STATS_EN: 3 ops for requester 0, 1 for requester 1 -> ops0=3, ops1=1.
